// File: rtl/vram_pkg.sv
// vram_pkg: copy-engine state, read-owner tags and parameter ranges for the port-A arbiter.
package vram_pkg;
    typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE} cpy_state_e;
    localparam logic TAG_VID = 1'b0;
    localparam logic TAG_CPY = 1'b1;
    localparam int DEF_AW = 8;
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 3;
endpackage

// File: rtl/vram_rd_tag_pipe.sv
// vram_rd_tag_pipe: follows each issued read through the BRAM latency so its data can be routed to its owner.
module vram_rd_tag_pipe #(
    parameter int RD_LAT = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic valid_i,
    input  logic owner_i,
    output logic valid_o,
    output logic owner_o
);
    logic [RD_LAT-1:0] vld_q, own_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= '0;
            own_q <= '0;
        end else begin
            vld_q <= RD_LAT'({vld_q, valid_i});
            own_q <= RD_LAT'({own_q, owner_i});
        end
    end

    assign valid_o = vld_q[RD_LAT-1];
    assign owner_o = own_q[RD_LAT-1];
endmodule

// File: rtl/vram_copy_arbiter.sv
// vram_copy_arbiter: shares BRAM port A between priority video reads and a byte-wise block-copy engine.
module vram_copy_arbiter
    import vram_pkg::*;
#(
    parameter int AW        = DEF_AW,
    parameter int RD_LAT    = 2,
    parameter int MAX_STALL = 8
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [AW-1:0] cmd_src,
    input  logic [AW-1:0] cmd_dst,
    input  logic [AW-1:0] cmd_len,
    output logic          busy,
    output logic          done,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_gnt,
    output logic          vid_rvalid,
    output logic [7:0]    vid_rdata,
    output logic          ram_ce,
    output logic          ram_oce,
    output logic          ram_wre,
    output logic [AW-1:0] ram_addr,
    output logic [7:0]    ram_din,
    input  logic [7:0]    ram_dout
);
    localparam int LAT = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN : (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;
    localparam logic [7:0] STALL_LIM = 8'(MAX_STALL);

    cpy_state_e    state_q;
    logic [AW-1:0] src_q, dst_q, len_q;
    logic [7:0]    stall_q, hold_q, vid_rdata_q;
    logic          done_q, vid_rvalid_q, run_q;
    logic          issue_st, cpy_win, cpy_go, tag_vld, tag_own;

    assign issue_st   = state_q == RD_ISSUE || state_q == WR_ISSUE;
    assign cpy_win    = !vid_req || stall_q == STALL_LIM;
    assign cpy_go     = issue_st && cpy_win;
    // run_q keeps the combinational grant quiet until the first clock after reset
    assign vid_gnt    = run_q && vid_req && !cpy_go;
    assign ram_ce     = cpy_go || vid_gnt;
    assign ram_wre    = cpy_go && state_q == WR_ISSUE;
    assign ram_addr   = cpy_go ? (state_q == WR_ISSUE ? dst_q : src_q) : vid_gnt ? vid_addr : '0;
    assign ram_din    = hold_q;
    assign ram_oce    = 1'b1;
    assign cmd_ready  = state_q == IDLE;
    assign busy       = state_q != IDLE;
    assign done       = done_q;
    assign vid_rvalid = vid_rvalid_q;
    assign vid_rdata  = vid_rdata_q;

    vram_rd_tag_pipe #(.RD_LAT(LAT)) u_tag (
        .clk_i   (sys_clk),
        .rst_ni  (sys_rst_n),
        .valid_i (ram_ce && !ram_wre),
        .owner_i (cpy_go ? TAG_CPY : TAG_VID),
        .valid_o (tag_vld),
        .owner_o (tag_own)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            run_q        <= 1'b0;
            vid_rvalid_q <= 1'b0;
            vid_rdata_q  <= '0;
            hold_q       <= '0;
        end else begin
            run_q        <= 1'b1;
            vid_rvalid_q <= tag_vld && tag_own == TAG_VID;
            if (tag_vld && tag_own == TAG_VID) vid_rdata_q <= ram_dout;
            if (tag_vld && tag_own == TAG_CPY) hold_q <= ram_dout;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            stall_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (issue_st) stall_q <= cpy_win ? 8'd0 : stall_q + 8'd1;
            case (state_q)
                IDLE: if (cmd_valid) begin
                    src_q <= cmd_src;
                    dst_q <= cmd_dst;
                    len_q <= cmd_len;
                    if (cmd_len == '0) done_q <= 1'b1;
                    else state_q <= RD_ISSUE;
                end
                RD_ISSUE: if (cpy_win) state_q <= RD_WAIT;
                RD_WAIT: if (tag_vld && tag_own == TAG_CPY) state_q <= WR_ISSUE;
                WR_ISSUE: if (cpy_win) begin
                    src_q <= src_q + AW'(1);
                    dst_q <= dst_q + AW'(1);
                    len_q <= len_q - AW'(1);
                    if (len_q == AW'(1)) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= RD_ISSUE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vram_copy_arbiter.sv
// tb_vram_copy_arbiter: directed scenarios against a BRAM model with hand-computed expectations.
module tb_vram_copy_arbiter;
    localparam int RD_LAT = 2;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       cmd_valid = 1'b0, cmd_ready;
    logic [7:0] cmd_src = '0, cmd_dst = '0, cmd_len = '0;
    logic       busy, done;
    logic       vid_req = 1'b0, vid_gnt, vid_rvalid;
    logic [7:0] vid_addr = '0, vid_rdata;
    logic       ram_ce, ram_oce, ram_wre;
    logic [7:0] ram_addr, ram_din, ram_dout;

    logic [7:0] mem [256];
    logic [7:0] dpipe [RD_LAT];
    logic       pl_en = 1'b0;
    logic [7:0] pl_addr = '0, pl_data = '0;
    int         cyc = 0, checks = 0, errors = 0;

    typedef struct {int cyc; logic wre; logic [7:0] addr; logic [7:0] din; logic busy;} op_t;
    op_t        ops[$];
    int         gnt_cyc[$], rv_cyc[$], done_cyc[$];
    logic [7:0] rv_dat[$];
    logic       done_busy[$];
    logic       busy_seen = 1'b0;

    vram_copy_arbiter #(.AW(8), .RD_LAT(RD_LAT), .MAX_STALL(8)) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_src    (cmd_src),
        .cmd_dst    (cmd_dst),
        .cmd_len    (cmd_len),
        .busy       (busy),
        .done       (done),
        .vid_req    (vid_req),
        .vid_addr   (vid_addr),
        .vid_gnt    (vid_gnt),
        .vid_rvalid (vid_rvalid),
        .vid_rdata  (vid_rdata),
        .ram_ce     (ram_ce),
        .ram_oce    (ram_oce),
        .ram_wre    (ram_wre),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .ram_dout   (ram_dout)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) begin
        cyc++;
        if (pl_en) mem[pl_addr] = pl_data;
        if (ram_ce && ram_wre) mem[ram_addr] = ram_din;
        dpipe[0] <= (ram_ce && !ram_wre) ? mem[ram_addr] : 8'hxx;
        for (int i = 1; i < RD_LAT; i++) dpipe[i] <= dpipe[i-1];
    end
    assign ram_dout = dpipe[RD_LAT-1];

    always @(negedge sys_clk) begin
        if (ram_ce) ops.push_back('{cyc, ram_wre, ram_addr, ram_din, busy});
        if (vid_gnt) gnt_cyc.push_back(cyc);
        if (vid_rvalid) begin
            rv_cyc.push_back(cyc);
            rv_dat.push_back(vid_rdata);
        end
        if (done) begin
            done_cyc.push_back(cyc);
            done_busy.push_back(busy);
        end
        if (busy) busy_seen = 1'b1;
    end

    task automatic tick;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        pl_en = 1'b1;
        pl_addr = a;
        pl_data = d;
        tick();
        pl_en = 1'b0;
    endtask

    task automatic clear_logs;
        ops.delete();
        gnt_cyc.delete();
        rv_cyc.delete();
        rv_dat.delete();
        done_cyc.delete();
        done_busy.delete();
        busy_seen = 1'b0;
    endtask

    task automatic start_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] n);
        cmd_valid = 1'b1;
        cmd_src = s;
        cmd_dst = d;
        cmd_len = n;
    endtask

    task automatic test_reset;
        repeat (3) tick();
        checks++;
        if ({busy, done, vid_gnt, vid_rvalid, ram_ce, ram_wre} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 000000", {busy, done, vid_gnt, vid_rvalid, ram_ce, ram_wre});
        end
        checks++;
        if ({vid_rdata, ram_addr, ram_din} !== 24'h0) begin
            errors++;
            $display("FAIL reset_data: got %h expected 000000", {vid_rdata, ram_addr, ram_din});
        end
        checks++;
        if ({cmd_ready, ram_oce} !== 2'b11) begin
            errors++;
            $display("FAIL reset_ready_oce: got %b expected 11", {cmd_ready, ram_oce});
        end
        sys_rst_n = 1'b1;
        repeat (2) tick();
        checks++;
        if ({cmd_ready, busy} !== 2'b10) begin
            errors++;
            $display("FAIL reset_release: got %b expected 10", {cmd_ready, busy});
        end
    endtask

    task automatic test_copy;
        int a;
        preload(8'h40, 8'h65);
        preload(8'h41, 8'hA3);
        preload(8'h20, 8'h00);
        preload(8'h21, 8'h00);
        clear_logs();
        a = cyc;
        start_copy(8'h40, 8'h20, 8'd2);
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 40 && done_cyc.size() == 0; i++) tick();
        repeat (2) tick();
        checks++;
        if (done_cyc.size() !== 1) begin
            errors++;
            $display("FAIL copy_done_count: got %0d expected 1", done_cyc.size());
        end
        checks++;
        if (ops.size() !== 4) begin
            errors++;
            $display("FAIL copy_op_count: got %0d expected 4", ops.size());
        end
        checks++;
        if ({ops[0].wre, ops[0].addr, ops[1].wre, ops[1].addr, ops[1].din} !== {1'b0, 8'h40, 1'b1, 8'h20, 8'h65}) begin
            errors++;
            $display("FAIL copy_byte0: got R%b@%h W%b@%h=%h expected R0@40 W1@20=65",
                     ops[0].wre, ops[0].addr, ops[1].wre, ops[1].addr, ops[1].din);
        end
        checks++;
        if ({ops[2].wre, ops[2].addr, ops[3].wre, ops[3].addr, ops[3].din} !== {1'b0, 8'h41, 1'b1, 8'h21, 8'hA3}) begin
            errors++;
            $display("FAIL copy_byte1: got R%b@%h W%b@%h=%h expected R0@41 W1@21=A3",
                     ops[2].wre, ops[2].addr, ops[3].wre, ops[3].addr, ops[3].din);
        end
        checks++;
        if (ops[0].cyc !== a + 1 || ops[0].busy !== 1'b1) begin
            errors++;
            $display("FAIL copy_start: got cycle %0d busy %b expected cycle %0d busy 1", ops[0].cyc, ops[0].busy, a + 1);
        end
        checks++;
        if (done_cyc[0] !== ops[0].cyc + 8) begin
            errors++;
            $display("FAIL copy_done_time: got %0d expected %0d", done_cyc[0], ops[0].cyc + 8);
        end
        checks++;
        if (done_busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL copy_busy_at_done: got %b expected 0", done_busy[0]);
        end
        checks++;
        if ({mem[8'h20], mem[8'h21]} !== 16'h65A3) begin
            errors++;
            $display("FAIL copy_mem: got %h expected 65a3", {mem[8'h20], mem[8'h21]});
        end
    endtask

    task automatic test_video;
        int g;
        preload(8'h10, 8'h5A);
        clear_logs();
        g = cyc;
        vid_req = 1'b1;
        vid_addr = 8'h10;
        tick();
        vid_req = 1'b0;
        repeat (5) tick();
        checks++;
        if (gnt_cyc.size() !== 1 || gnt_cyc[0] !== g) begin
            errors++;
            $display("FAIL video_gnt: got %0d grants first at %0d expected 1 at %0d", gnt_cyc.size(), gnt_cyc[0], g);
        end
        checks++;
        if ({ops[0].wre, ops[0].addr} !== {1'b0, 8'h10}) begin
            errors++;
            $display("FAIL video_op: got wre %b addr %h expected 0 10", ops[0].wre, ops[0].addr);
        end
        checks++;
        if (rv_cyc.size() !== 1 || rv_cyc[0] !== g + 3) begin
            errors++;
            $display("FAIL video_rvalid: got %0d pulses first at %0d expected 1 at %0d", rv_cyc.size(), rv_cyc[0], g + 3);
        end
        checks++;
        if (rv_dat[0] !== 8'h5A) begin
            errors++;
            $display("FAIL video_rdata: got %h expected 5a", rv_dat[0]);
        end
    endtask

    task automatic test_stall;
        int a, rd_c, wr_c, wr_n, win_gnts, bad;
        logic [7:0] wr_a, wr_d;
        preload(8'h30, 8'h77);
        preload(8'h50, 8'hC4);
        preload(8'h60, 8'h00);
        clear_logs();
        a = cyc;
        start_copy(8'h50, 8'h60, 8'd1);
        vid_req = 1'b1;
        vid_addr = 8'h30;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 60 && done_cyc.size() == 0; i++) tick();
        vid_req = 1'b0;
        repeat (6) tick();
        rd_c = -1;
        wr_c = -1;
        wr_n = 0;
        wr_a = '0;
        wr_d = '0;
        foreach (ops[i]) begin
            if (!ops[i].wre && ops[i].addr == 8'h50) rd_c = ops[i].cyc;
            if (ops[i].wre) begin
                wr_n++;
                wr_c = ops[i].cyc;
                wr_a = ops[i].addr;
                wr_d = ops[i].din;
            end
        end
        win_gnts = 0;
        foreach (gnt_cyc[i]) if (gnt_cyc[i] >= a && gnt_cyc[i] <= a + 20) win_gnts++;
        bad = 0;
        foreach (rv_dat[i]) if (rv_dat[i] !== 8'h77) bad++;
        checks++;
        if (rd_c !== a + 9) begin
            errors++;
            $display("FAIL stall_read_slot: got %0d expected %0d", rd_c, a + 9);
        end
        checks++;
        if (wr_n !== 1 || wr_c !== a + 20) begin
            errors++;
            $display("FAIL stall_write_slot: got %0d writes last at %0d expected 1 at %0d", wr_n, wr_c, a + 20);
        end
        checks++;
        if ({wr_a, wr_d} !== 16'h60C4) begin
            errors++;
            $display("FAIL stall_write_data: got %h expected 60c4", {wr_a, wr_d});
        end
        checks++;
        if (win_gnts !== 19) begin
            errors++;
            $display("FAIL stall_gnt_count: got %0d expected 19", win_gnts);
        end
        checks++;
        if (done_cyc[0] !== a + 21) begin
            errors++;
            $display("FAIL stall_done_time: got %0d expected %0d", done_cyc[0], a + 21);
        end
        checks++;
        if (rv_cyc.size() !== gnt_cyc.size() || bad !== 0) begin
            errors++;
            $display("FAIL stall_video_data: got %0d rvalid %0d bad expected %0d rvalid 0 bad", rv_cyc.size(), bad, gnt_cyc.size());
        end
        checks++;
        if (mem[8'h60] !== 8'hC4) begin
            errors++;
            $display("FAIL stall_mem: got %h expected c4", mem[8'h60]);
        end
    endtask

    task automatic test_wrap;
        preload(8'hFF, 8'h11);
        preload(8'h00, 8'h22);
        preload(8'h7F, 8'h00);
        preload(8'h80, 8'h00);
        clear_logs();
        start_copy(8'hFF, 8'h7F, 8'd2);
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 40 && done_cyc.size() == 0; i++) tick();
        repeat (2) tick();
        checks++;
        if (ops.size() !== 4) begin
            errors++;
            $display("FAIL wrap_op_count: got %0d expected 4", ops.size());
        end
        checks++;
        if ({ops[0].wre, ops[0].addr, ops[2].wre, ops[2].addr} !== {1'b0, 8'hFF, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL wrap_reads: got %b@%h %b@%h expected 0@ff 0@00", ops[0].wre, ops[0].addr, ops[2].wre, ops[2].addr);
        end
        checks++;
        if ({ops[1].wre, ops[1].addr, ops[1].din, ops[3].wre, ops[3].addr, ops[3].din} !== {1'b1, 8'h7F, 8'h11, 1'b1, 8'h80, 8'h22}) begin
            errors++;
            $display("FAIL wrap_writes: got %b@%h=%h %b@%h=%h expected 1@7f=11 1@80=22",
                     ops[1].wre, ops[1].addr, ops[1].din, ops[3].wre, ops[3].addr, ops[3].din);
        end
        checks++;
        if ({mem[8'h7F], mem[8'h80]} !== 16'h1122) begin
            errors++;
            $display("FAIL wrap_mem: got %h expected 1122", {mem[8'h7F], mem[8'h80]});
        end
    endtask

    task automatic test_zero;
        int a;
        clear_logs();
        a = cyc;
        start_copy(8'h33, 8'h44, 8'd0);
        tick();
        cmd_valid = 1'b0;
        repeat (4) tick();
        checks++;
        if (done_cyc.size() !== 1 || done_cyc[0] !== a + 1) begin
            errors++;
            $display("FAIL zero_done: got %0d pulses first at %0d expected 1 at %0d", done_cyc.size(), done_cyc[0], a + 1);
        end
        checks++;
        if (ops.size() !== 0 || busy_seen !== 1'b0) begin
            errors++;
            $display("FAIL zero_idle: got %0d ops busy_seen %b expected 0 ops busy_seen 0", ops.size(), busy_seen);
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL zero_ready: got %b expected 1", cmd_ready);
        end
    endtask

    task automatic test_reset_mid;
        int wr_n;
        preload(8'h90, 8'hEE);
        clear_logs();
        start_copy(8'h40, 8'h90, 8'd1);
        tick();
        cmd_valid = 1'b0;
        tick();
        vid_req = 1'b1;
        vid_addr = 8'h10;
        tick();
        vid_req = 1'b0;
        sys_rst_n = 1'b0;
        repeat (2) tick();
        sys_rst_n = 1'b1;
        repeat (6) tick();
        wr_n = 0;
        foreach (ops[i]) if (ops[i].wre) wr_n++;
        checks++;
        if (ops.size() !== 2 || wr_n !== 0) begin
            errors++;
            $display("FAIL midreset_ops: got %0d ops %0d writes expected 2 ops 0 writes", ops.size(), wr_n);
        end
        checks++;
        if (rv_cyc.size() !== 0 || done_cyc.size() !== 0) begin
            errors++;
            $display("FAIL midreset_outputs: got %0d rvalid %0d done expected 0 0", rv_cyc.size(), done_cyc.size());
        end
        checks++;
        if ({cmd_ready, busy} !== 2'b10) begin
            errors++;
            $display("FAIL midreset_state: got %b expected 10", {cmd_ready, busy});
        end
        checks++;
        if (mem[8'h90] !== 8'hEE) begin
            errors++;
            $display("FAIL midreset_mem: got %h expected ee", mem[8'h90]);
        end
    endtask

    initial begin
        test_reset();
        test_copy();
        test_video();
        test_stall();
        test_wrap();
        test_zero();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
